// File: rtl/div_unit_pkg.sv
// Shared CPU package slice: divider FSM encoding and default operand width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_diff_msb;

  // rem_i < dvs_i keeps the difference inside WIDTH bits whenever it is kept
  assign unused_diff_msb = diff[WIDTH];

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_i};
    if (diff[WIDTH+1]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative WIDTH-cycle restoring divider for the EX stage, with cancel on flush.
// Signed DIV support is built only when DIV_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo;

`ifdef DIV_SIGNED_EN
  assign sgn = signed_op;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn = 1'b0;
`endif

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    a_d           = a_q;
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            a_d     = a;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dbz_d   = (b == '0);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = ST_DONE;
            // Divide-by-zero bypasses sign fixup: all ones and the raw dividend
            if (dbz_q) begin
              quotient_d  = '1;
              remainder_d = a_q;
            end else begin
              quotient_d  = qneg_q ? (~step_quo + 1'b1) : step_quo;
              remainder_d = rneg_q ? (~step_rem + 1'b1) : step_rem;
            end
            div_by_zero_d = dbz_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      a_q           <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      a_q           <= a_d;
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE) & ~cancel;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, div-by-zero, cancel, back-to-back, reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, cancel;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, bcnt;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one op, then count cycles until done (bounded); busy counted per cycle
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
    a = av; b = bv; signed_op = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic expect_no_done(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen |= done;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic z);
    check({tag, "_lat"}, lat, 32);
    check({tag, "_q"}, quotient, q);
    check({tag, "_r"}, remainder, r);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", {31'd0, div_by_zero}, 0);

    run_op(32'd100, 32'd7, 1'b0);
    check_res("u100_7", 32'd14, 32'd2, 1'b0);
    check("u100_7_busy", bcnt, 32);
    tick();
    check("done_pulse", {31'd0, done}, 0);
    check("idle_busy", {31'd0, busy}, 0);

    run_op(32'd5, 32'd0, 1'b0);
    check_res("dbz5", 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0);
    check_res("umax", 32'h0FFF_FFFF, 32'hF, 1'b0);
    run_op(32'h8000_0000, 32'd3, 1'b0);
    check_res("u80_3", 32'h2AAA_AAAA, 32'd2, 1'b0);
    run_op(32'd3, 32'd10, 1'b0);
    check_res("small", 32'd0, 32'd3, 1'b0);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    check_res("s_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_res("s_min_m1", 32'h8000_0000, 32'd0, 1'b0);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1);
    check_res("s_100_m7", 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1);
    check_res("s_dbz", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run_op(32'd100, 32'd7, 1'b0);
    check_res("u100_7b", 32'd14, 32'd2, 1'b0);
`else
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1);
    check_res("nosgn", 32'h2492_4916, 32'd2, 1'b0);
    run_op(32'd100, 32'd7, 1'b0);
    check_res("u100_7b", 32'd14, 32'd2, 1'b0);
`endif

    // Cancel at RUN cycle 10: outputs keep 14/2 from the previous op
    a = 32'd9; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_cancel_busy", {31'd0, busy}, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 0);
    check("cancel_q", quotient, 32'd14);
    check("cancel_r", remainder, 32'd2);
    check("cancel_dbz", {31'd0, div_by_zero}, 0);
    expect_no_done("cancel_nodone", 40);

    // start together with cancel in IDLE is dropped
    a = 32'd50; b = 32'd5; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("stcan_busy", {31'd0, busy}, 0);
    expect_no_done("stcan_nodone", 40);

    // Back-to-back: start held; operands changed mid-RUN are only seen at DONE
    a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    a = 32'd50; b = 32'd6;
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    check("b2b1_lat", lat, 32);
    check("b2b1_q", quotient, 32'd14);
    check("b2b1_r", remainder, 32'd2);
    tick();
    lat++;
    check("b2b_accept_busy", {31'd0, busy}, 1);
    check("b2b_accept_done", {31'd0, done}, 0);
    start = 1'b0;
    while (!done && lat < 200) begin tick(); lat++; end
    check("b2b2_lat", lat, 65);
    check("b2b2_q", quotient, 32'd8);
    check("b2b2_r", remainder, 32'd2);

    // Reset mid-RUN clears everything; a fresh op then works
    tick();
    a = 32'd77; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1; start = 1'b1; cancel = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_done", {31'd0, done}, 0);
    check("mrst_q", quotient, 0);
    check("mrst_r", remainder, 0);
    check("mrst_dbz", {31'd0, div_by_zero}, 0);
    expect_no_done("mrst_nodone", 40);
    run_op(32'd1000, 32'd33, 1'b0);
    check_res("post_rst", 32'd30, 32'd10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
